stream_tap_router: RTL and testbench

- Parametrised successor to the fixed ADC→L1 trigger→buf/dac hookup. Routes any of NCH ADC channels, at a selectable tap point (raw, filtered, or test pattern), to any of NOUT AXI4-Stream outputs feeding capture buffers and DACs.
- Tap selection is register-controlled and applied only on frame boundaries, so captures never contain a mid-frame source switch.
- Each output carries frame markers (tlast) and a trigger marker (tuser).
- Sits between the L1 trigger wrapper and the buffer/DAC stream ports; runs in the aclk domain.

---
 rtl/stream_tap_pkg.sv | 53 +++++
 rtl/stream_tap_router_lane.sv | 106 ++++++++++
 rtl/stream_tap_router.sv | 163 ++++++++++++++++
 tb/tb_stream_tap_router.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_tap_pkg.sv
// Shared types, constants and packing helpers for the stream tap router.
// Build option: STREAM_TAP_ROUTER_TESTPAT_EN enables the ramp test-pattern source.
package stream_tap_pkg;

    localparam int SAMPLES_PER_BEAT = 8;
    localparam int RAW_BITS         = 12;
    localparam int LANE_BITS        = 16;
    localparam int LSB_PAD          = 4;
    localparam int RAW_BEAT_BITS    = SAMPLES_PER_BEAT * RAW_BITS;
    localparam int OUT_BEAT_BITS    = SAMPLES_PER_BEAT * LANE_BITS;

    typedef enum logic [1:0] {
        SRC_RAW  = 2'd0,
        SRC_FILT = 2'd1,
        SRC_TEST = 2'd2
    } tap_src_t;

    typedef struct packed {
        logic [7:0] channel;
        tap_src_t   src;
    } tap_sel_t;

    // Places eight 12-bit samples left-justified in 16-bit lanes, low pad bits zero.
    function automatic logic [OUT_BEAT_BITS-1:0] pack_raw(
        input logic [RAW_BEAT_BITS-1:0] samples
    );
        logic [OUT_BEAT_BITS-1:0] beat;
        beat = '0;
        for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
            beat[i*LANE_BITS+LSB_PAD +: RAW_BITS] = samples[i*RAW_BITS +: RAW_BITS];
        end
        return beat;
    endfunction

    // Unpacks eight fbits-wide samples stored contiguously from bit 0 and places
    // each zero-extended just above the lane's pad bits.
    function automatic logic [OUT_BEAT_BITS-1:0] pack_filt(
        input logic [RAW_BEAT_BITS-1:0] samples,
        input int unsigned              fbits
    );
        logic [OUT_BEAT_BITS-1:0] beat;
        logic [RAW_BITS-1:0]      mask;
        logic [RAW_BITS-1:0]      smp;
        beat = '0;
        mask = RAW_BITS'((13'd1 << fbits) - 13'd1);
        for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
            smp = samples[i*fbits +: RAW_BITS] & mask;
            beat[i*LANE_BITS+LSB_PAD +: RAW_BITS] = smp;
        end
        return beat;
    endfunction

endpackage

// File: rtl/stream_tap_router_lane.sv
// One output stream of the tap router: source mux, packing, frame/trigger
// markers and sticky overflow flag. Two register stages, never stalls.
// Build option: STREAM_TAP_ROUTER_TESTPAT_EN adds the ramp source.
module tap_lane
    import stream_tap_pkg::*;
#(
    parameter int NCH       = 8,
    parameter int FILT_BITS = 5
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [RAW_BEAT_BITS-1:0]              raw_i  [NCH],
    input  logic [SAMPLES_PER_BEAT*FILT_BITS-1:0] filt_i [NCH],
    input  logic                                  trig_i,
    input  logic                                  last_i,
`ifdef STREAM_TAP_ROUTER_TESTPAT_EN
    input  logic [8:0]                            beat_cnt_i,
`endif
    input  tap_sel_t                              sel_i,
    input  logic                                  ovf_clr_i,
    input  logic                                  tready_i,
    output logic [OUT_BEAT_BITS-1:0]              tdata_o,
    output logic                                  tvalid_o,
    output logic                                  tlast_o,
    output logic                                  tuser_o,
    output logic                                  ovf_o
);

    logic [RAW_BEAT_BITS-1:0] s1_data_d;
    logic [RAW_BEAT_BITS-1:0] s1_data_q;
    tap_src_t                 s1_src_q;
    logic                     s1_valid_q;
    logic                     s1_last_q;
    logic                     s1_user_q;

    logic [OUT_BEAT_BITS-1:0] tdata_q;
    logic                     tvalid_q;
    logic                     tlast_q;
    logic                     tuser_q;
    logic                     ovf_q;

    // Stage-1 source select: pick the channel's raw or filtered beat, or build the ramp.
    always_comb begin
        s1_data_d = '0;
        for (int c = 0; c < NCH; c++) begin
            if (sel_i.channel == 8'(c)) begin
                if (sel_i.src == SRC_FILT) begin
                    s1_data_d = RAW_BEAT_BITS'(filt_i[c]);
                end else begin
                    s1_data_d = raw_i[c];
                end
            end
        end
`ifdef STREAM_TAP_ROUTER_TESTPAT_EN
        if (sel_i.src == SRC_TEST) begin
            for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
                s1_data_d[i*RAW_BITS +: RAW_BITS] = {beat_cnt_i, 3'(i)};
            end
        end
`endif
    end

    // Pipeline registers: stage 1 holds the selected beat, stage 2 the packed output.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_data_q  <= '0;
            s1_src_q   <= SRC_RAW;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_user_q  <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_src_q   <= sel_i.src;
            s1_valid_q <= 1'b1;
            s1_last_q  <= last_i;
            s1_user_q  <= trig_i;
            tdata_q    <= (s1_src_q == SRC_FILT) ? pack_filt(s1_data_q, FILT_BITS)
                                                 : pack_raw(s1_data_q);
            tvalid_q   <= s1_valid_q;
            tlast_q    <= s1_last_q;
            tuser_q    <= s1_user_q;
        end
    end

    // Sticky overflow: a beat offered while the sink is not ready is lost; a drop beats a clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ovf_q <= 1'b0;
        end else if (tvalid_q && !tready_i) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
        end
    end

    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;
    assign tuser_o  = tuser_q;
    assign ovf_o    = ovf_q;

endmodule

// File: rtl/stream_tap_router.sv
// Routes any ADC channel at a chosen tap point to any of NOUT AXI4-Stream
// outputs. Selections are staged in shadow registers and applied together at
// frame boundaries so a capture never switches source mid-frame.
// Build option: STREAM_TAP_ROUTER_TESTPAT_EN enables source 2 (ramp pattern);
// without it source 2 is rejected like the reserved code.
module stream_tap_router
    import stream_tap_pkg::*;
#(
    parameter int NCH       = 8,
    parameter int NOUT      = 4,
    parameter int FILT_BITS = 5,
    parameter int NBEAMS    = 2,
    parameter int FRAME_LEN = 1024,
    localparam int AW       = (NOUT > 1) ? $clog2(NOUT) : 1
) (
    input  logic                                  aclk,
    input  logic                                  aresetn,
    input  logic [RAW_BEAT_BITS-1:0]              raw_i  [NCH],
    input  logic [SAMPLES_PER_BEAT*FILT_BITS-1:0] filt_i [NCH],
    input  logic [NBEAMS-1:0]                     trig_i,
    input  logic                                  cfg_wr_i,
    input  logic [AW-1:0]                         cfg_addr_i,
    input  logic [15:0]                           cfg_dat_i,
    output logic                                  cfg_err_o,
    output logic [NOUT*OUT_BEAT_BITS-1:0]         mNN_tdata,
    output logic [NOUT-1:0]                       mNN_tvalid,
    input  logic [NOUT-1:0]                       mNN_tready,
    output logic [NOUT-1:0]                       mNN_tlast,
    output logic [NOUT-1:0]                       mNN_tuser,
    output logic [NOUT-1:0]                       ovf_o
);

    localparam int FCW = $clog2(FRAME_LEN);

    logic [FCW-1:0] fcnt_q;
    logic           frame_start;
    logic           frame_last;
    logic           trig_any;

    tap_sel_t       shadow_q [NOUT];
    tap_sel_t       active_q [NOUT];
    tap_sel_t       sel_eff  [NOUT];

    tap_sel_t       wr_sel;
    logic           addr_ok;
    logic           sel_ok;
    logic           cfg_accept;
    logic           cfg_reject;
    logic [NOUT-1:0] ovf_clr;
    logic           cfg_err_q;
    logic           cfg_unused;

`ifdef STREAM_TAP_ROUTER_TESTPAT_EN
    logic [8:0]     beat_cnt_q;
`endif

    assign frame_start = (fcnt_q == '0);
    assign frame_last  = (fcnt_q == FCW'(FRAME_LEN - 1));
    assign trig_any    = |trig_i;
    assign cfg_unused  = ^cfg_dat_i[14:10];

    // Config decode: validate the index and select fields, derive per-output clears.
    always_comb begin
        wr_sel.channel = cfg_dat_i[7:0];
        wr_sel.src     = tap_src_t'(cfg_dat_i[9:8]);
        addr_ok        = (int'(cfg_addr_i) < NOUT);
`ifdef STREAM_TAP_ROUTER_TESTPAT_EN
        sel_ok         = (int'(cfg_dat_i[7:0]) < NCH) && (cfg_dat_i[9:8] != 2'd3);
`else
        sel_ok         = (int'(cfg_dat_i[7:0]) < NCH) && (cfg_dat_i[9:8] < 2'd2);
`endif
        cfg_accept     = cfg_wr_i && addr_ok && sel_ok;
        cfg_reject     = cfg_wr_i && !(addr_ok && sel_ok);
        for (int o = 0; o < NOUT; o++) begin
            ovf_clr[o] = cfg_wr_i && cfg_dat_i[15] && addr_ok && (cfg_addr_i == AW'(o));
        end
    end

    // On a frame's first beat the mux sees the shadow directly so beat 0 already uses it.
    always_comb begin
        for (int o = 0; o < NOUT; o++) begin
            sel_eff[o] = frame_start ? shadow_q[o] : active_q[o];
        end
    end

    // Shadow takes accepted writes; active copies the old shadow at each frame start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int o = 0; o < NOUT; o++) begin
                shadow_q[o].channel <= 8'(o % NCH);
                shadow_q[o].src     <= SRC_RAW;
                active_q[o].channel <= 8'(o % NCH);
                active_q[o].src     <= SRC_RAW;
            end
        end else begin
            for (int o = 0; o < NOUT; o++) begin
                if (cfg_accept && (cfg_addr_i == AW'(o))) begin
                    shadow_q[o] <= wr_sel;
                end
                if (frame_start) begin
                    active_q[o] <= shadow_q[o];
                end
            end
        end
    end

    // Shared frame position of the beat currently entering stage 1; wraps silently.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + FCW'(1);
        end
    end

`ifdef STREAM_TAP_ROUTER_TESTPAT_EN
    // Ramp beat counter, advances once per beat and wraps at 512.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_q + 9'd1;
        end
    end
`endif

    // Rejected writes produce a single-cycle error pulse.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_reject;
        end
    end

    assign cfg_err_o = cfg_err_q;

    for (genvar o = 0; o < NOUT; o++) begin : g_lane
        tap_lane #(
            .NCH       (NCH),
            .FILT_BITS (FILT_BITS)
        ) u_lane (
            .aclk       (aclk),
            .aresetn    (aresetn),
            .raw_i      (raw_i),
            .filt_i     (filt_i),
            .trig_i     (trig_any),
            .last_i     (frame_last),
`ifdef STREAM_TAP_ROUTER_TESTPAT_EN
            .beat_cnt_i (beat_cnt_q),
`endif
            .sel_i      (sel_eff[o]),
            .ovf_clr_i  (ovf_clr[o]),
            .tready_i   (mNN_tready[o]),
            .tdata_o    (mNN_tdata[o*OUT_BEAT_BITS +: OUT_BEAT_BITS]),
            .tvalid_o   (mNN_tvalid[o]),
            .tlast_o    (mNN_tlast[o]),
            .tuser_o    (mNN_tuser[o]),
            .ovf_o      (ovf_o[o])
        );
    end

endmodule

// File: tb/tb_stream_tap_router.sv
// Directed bench for stream_tap_router: expected beats are queued as inputs are
// driven and popped two cycles later when the router emits them.
module tb_stream_tap_router;

    localparam int NCH  = 8;
    localparam int NOUT = 4;
    localparam int FB   = 5;
    localparam int NB   = 2;
    localparam int FL   = 1024;

    logic                  aclk    = 1'b0;
    logic                  aresetn = 1'b1;
    logic [95:0]           raw  [NCH];
    logic [8*FB-1:0]       filt [NCH];
    logic [NB-1:0]         trig;
    logic                  cfgWr;
    logic [1:0]            cfgAddr;
    logic [15:0]           cfgDat;
    logic                  cfgErr;
    logic [NOUT*128-1:0]   tdata;
    logic [NOUT-1:0]       tvalid;
    logic [NOUT-1:0]       tready;
    logic [NOUT-1:0]       tlast;
    logic [NOUT-1:0]       tuser;
    logic [NOUT-1:0]       ovf;

    always #5 aclk = ~aclk;

    stream_tap_router #(
        .NCH(NCH), .NOUT(NOUT), .FILT_BITS(FB), .NBEAMS(NB), .FRAME_LEN(FL)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .raw_i      (raw),
        .filt_i     (filt),
        .trig_i     (trig),
        .cfg_wr_i   (cfgWr),
        .cfg_addr_i (cfgAddr),
        .cfg_dat_i  (cfgDat),
        .cfg_err_o  (cfgErr),
        .mNN_tdata  (tdata),
        .mNN_tvalid (tvalid),
        .mNN_tready (tready),
        .mNN_tlast  (tlast),
        .mNN_tuser  (tuser),
        .ovf_o      (ovf)
    );

    typedef struct {
        logic [NOUT*128-1:0] data;
        logic [NOUT-1:0]     last;
        logic [NOUT-1:0]     user;
    } exp_t;

    exp_t            sb[$];
    int              checks   = 0;
    int              failures = 0;

    logic [7:0]      shCh  [NOUT];
    logic [1:0]      shSrc [NOUT];
    logic [7:0]      acCh  [NOUT];
    logic [1:0]      acSrc [NOUT];
    int              frameIdx;
    int              beatIdx;
    logic [NOUT-1:0] ovfExp;
    logic            errExp;
    logic            tvalidNow;
    logic            forceFilt5 = 1'b0;

    task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected 128-bit beat for one output from the inputs currently driven.
    function automatic logic [127:0] expBeat(input logic [7:0] ch, input logic [1:0] src, input int bi);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            case (src)
                2'd0:    b[16*i+4 +: 12] = raw[ch][12*i +: 12];
                2'd1:    b[16*i+4 +: FB] = filt[ch][FB*i +: FB];
                default: b[16*i+4 +: 12] = 12'((8*bi + i) % 4096);
            endcase
        end
        return b;
    endfunction

    // Compare every output against the beat driven two cycles earlier.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            tvalidNow = 1'b1;
        end else begin
            e.data = '0;
            e.last = '0;
            e.user = '0;
            tvalidNow = 1'b0;
        end
        cmp("tvalid", 128'(tvalid), 128'({NOUT{tvalidNow}}));
        for (int o = 0; o < NOUT; o++) begin
            cmp($sformatf("tdata%0d", o), tdata[o*128 +: 128], e.data[o*128 +: 128]);
        end
        cmp("tlast", 128'(tlast), 128'(e.last));
        cmp("tuser", 128'(tuser), 128'(e.user));
        cmp("ovf", 128'(ovf), 128'(ovfExp));
        cmp("cfg_err", 128'(cfgErr), 128'(errExp));
    endtask

    // Drive one input beat (plus optional config write) and queue what it must produce.
    task automatic applyStimulus(input logic doWr, input logic [1:0] addr, input logic [15:0] dat,
                                 input logic [NB-1:0] trigVal, input logic [NOUT-1:0] rdy);
        exp_t       e;
        logic       rej;
        logic [7:0] ch;
        logic [1:0] src;
        for (int c = 0; c < NCH; c++) begin
            raw[c]  = {$urandom, $urandom, $urandom};
            filt[c] = 40'({$urandom, $urandom});
        end
        if (forceFilt5) filt[5][4:0] = 5'h1F;
        trig    = trigVal;
        tready  = rdy;
        cfgWr   = doWr;
        cfgAddr = addr;
        cfgDat  = dat;
        if (frameIdx == 0) begin
            for (int o = 0; o < NOUT; o++) begin
                acCh[o]  = shCh[o];
                acSrc[o] = shSrc[o];
            end
        end
        for (int o = 0; o < NOUT; o++) begin
            e.data[o*128 +: 128] = expBeat(acCh[o], acSrc[o], beatIdx);
        end
        e.last = {NOUT{frameIdx == FL-1}};
        e.user = {NOUT{|trigVal}};
        sb.push_back(e);
        for (int o = 0; o < NOUT; o++) begin
            if (tvalidNow && !rdy[o]) ovfExp[o] = 1'b1;
            else if (doWr && dat[15] && addr == 2'(o)) ovfExp[o] = 1'b0;
        end
        ch  = dat[7:0];
        src = dat[9:8];
        rej = (ch >= 8'(NCH)) || (src == 2'd3);
`ifndef STREAM_TAP_ROUTER_TESTPAT_EN
        rej = rej || (src == 2'd2);
`endif
        errExp = doWr && rej;
        if (doWr && !rej) begin
            shCh[addr]  = ch;
            shSrc[addr] = src;
        end
        frameIdx = (frameIdx + 1) % FL;
        beatIdx++;
    endtask

    task automatic cycle(input logic doWr, input logic [1:0] addr, input logic [15:0] dat,
                         input logic [NB-1:0] trigVal, input logic [NOUT-1:0] rdy);
        @(posedge aclk);
        #1;
        checkOutput();
        applyStimulus(doWr, addr, dat, trigVal, rdy);
    endtask

    task automatic idle();
        cycle(1'b0, 2'd0, 16'h0000, '0, '1);
    endtask

    // Assert reset now, check the reset state, release it and drive beat 0.
    task automatic doReset();
        aresetn = 1'b0;
        cfgWr = 1'b0; cfgAddr = '0; cfgDat = '0; trig = '0; tready = '1;
        sb.delete();
        for (int o = 0; o < NOUT; o++) begin
            shCh[o] = 8'(o % NCH); shSrc[o] = 2'd0;
            acCh[o] = 8'(o % NCH); acSrc[o] = 2'd0;
        end
        frameIdx = 0; beatIdx = 0; ovfExp = '0; errExp = 1'b0; tvalidNow = 1'b0;
        #1;
        checkOutput();
        repeat (2) @(posedge aclk);
        #1;
        checkOutput();
        @(negedge aclk);
        aresetn = 1'b1;
        applyStimulus(1'b0, 2'd0, 16'h0000, '0, '1);
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            raw[c] = '0;
            filt[c] = '0;
        end
        #2;
        doReset();
        repeat (20) idle();

        // Retarget output 1 to filtered channel 5 in the middle of frame 0.
        while (frameIdx != 100) idle();
        cycle(1'b1, 2'd1, 16'h0105, '0, '1);
        while (frameIdx != 0) idle();
        forceFilt5 = 1'b1;
        idle();
        forceFilt5 = 1'b0;
        idle();
        idle();
        cmp("out1_beat0_filt5", 128'(tdata[128+4 +: 5]), 128'(5'h1F));
        cmp("out1_beat0_pad", 128'(tdata[128 +: 4]), 128'(4'h0));

        // Rejected channel, then a write landing exactly on the load cycle.
        repeat (10) idle();
        cycle(1'b1, 2'd0, 16'h0009, '0, '1);
        repeat (3) idle();
        while (frameIdx != 0) idle();
        cycle(1'b1, 2'd2, 16'h0007, '0, '1);
        while (frameIdx != 0) idle();
        repeat (20) idle();

        // Single-beat trigger on beam 1.
        cycle(1'b0, 2'd0, 16'h0000, 2'b10, '1);
        repeat (5) idle();

        // Backpressure on output 3, clears, and a clear racing a drop.
        repeat (3) cycle(1'b0, 2'd0, 16'h0000, '0, 4'b0111);
        repeat (3) idle();
        cycle(1'b1, 2'd3, 16'h8003, '0, '1);
        repeat (2) idle();
        cycle(1'b1, 2'd3, 16'h8003, '0, 4'b0111);
        repeat (2) idle();
        cycle(1'b1, 2'd3, 16'h8003, '0, '1);
        repeat (2) idle();

        // Test-pattern source on output 0 (rejected when the ramp is not built in).
        cycle(1'b1, 2'd0, 16'h0200, '0, '1);
        while (frameIdx != 0) idle();
        repeat (30) idle();

        // Mid-frame reset, then confirm the next frame restarts at beat 0.
        while (frameIdx != 500) idle();
        @(posedge aclk);
        #3;
        doReset();
        while (frameIdx != 0) idle();
        repeat (4) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
